// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF sync, per-button debounce, prioritised one-cycle press pulses.
// Optional auto-repeat for arriba/abajo is compiled in with `define BUTTON_AUTOREPEAT_EN.
// Bit order of all 5-bit vectors: {centro, izquierda, derecha, abajo, arriba}.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Barriba,
    input  logic       Babajo,
    input  logic       Bderecha,
    input  logic       Bizquierda,
    input  logic       Bcentro,
    output logic       Parriba,
    output logic       Pabajo,
    output logic       Pderecha,
    output logic       Pizquierda,
    output logic       Pcentro,
    output logic [4:0] Nivel,
    output logic       Ocupado
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat_cfg
        $error("button_conditioner: REPEAT_PERIOD must lie in 1..REPEAT_DELAY");
    end

    logic [4:0] raw, s1_q, s2_q, lvl_q, lvl_d, rise_q, rise_d, pnd_q, pnd_d, p_q, cand, sel, rep;
    logic ocu_q;
    logic [DW-1:0] cnt_q [5];
    logic [DW-1:0] cnt_d [5];

    assign raw = {Bcentro, Bizquierda, Bderecha, Babajo, Barriba};

    // two-flop synchronizer ahead of all other logic
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // debounce: count consecutive samples differing from the accepted level, accept on the last one
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DMAX) lvl_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [RW-1:0] RFIRE   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RRELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rcnt_q [2];
    logic [RW-1:0] rcnt_d [2];

    // hold timer for arriba/abajo; reload after each fire so later fires are REPEAT_PERIOD apart
    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) begin
            rep[i]    = lvl_q[i] && (rcnt_q[i] == RFIRE);
            rcnt_d[i] = !lvl_q[i] ? {RW{1'b0}} : rep[i] ? RRELOAD : rcnt_q[i] + 1'b1;
        end
    end

    // repeat timer state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rcnt_q <= '{default: '0};
        else rcnt_q <= rcnt_d;
    end
`else
    assign rep = '0;
`endif

    // arbitration: fixed priority centro > arriba > abajo > derecha > izquierda
    always_comb begin
        rise_d = (lvl_d & ~lvl_q) | rep;
        cand   = pnd_q | rise_q;
        sel    = cand[4] ? 5'b10000 :
                 cand[0] ? 5'b00001 :
                 cand[1] ? 5'b00010 :
                 cand[2] ? 5'b00100 :
                 cand[3] ? 5'b01000 : 5'b00000;
        pnd_d  = cand & ~sel;
    end

    // debounce, request, pending and pulse registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q  <= '{default: '0};
            lvl_q  <= '0;
            rise_q <= '0;
            pnd_q  <= '0;
            p_q    <= '0;
            ocu_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            pnd_q  <= pnd_d;
            p_q    <= sel;
            ocu_q  <= |pnd_d;
        end
    end

    assign {Pcentro, Pizquierda, Pderecha, Pabajo, Parriba} = p_q;
    assign Nivel   = lvl_q;
    assign Ocupado = ocu_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of sync/debounce latency, glitch rejection, priority, repeat and reset.
module tb_button_conditioner;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic CLK = 1'b0, RST = 1'b1;
    logic Barriba = 0, Babajo = 0, Bderecha = 0, Bizquierda = 0, Bcentro = 0;
    logic Parriba, Pabajo, Pderecha, Pizquierda, Pcentro, Ocupado;
    logic [4:0] Nivel, pv;
    int nvec = 0, nerr = 0, cyc = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
        .CLK(CLK), .RST(RST),
        .Barriba(Barriba), .Babajo(Babajo), .Bderecha(Bderecha), .Bizquierda(Bizquierda), .Bcentro(Bcentro),
        .Parriba(Parriba), .Pabajo(Pabajo), .Pderecha(Pderecha), .Pizquierda(Pizquierda), .Pcentro(Pcentro),
        .Nivel(Nivel), .Ocupado(Ocupado)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign pv = {Pcentro, Pizquierda, Pderecha, Pabajo, Parriba};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        nvec++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset_p", pv, 5'b0);
        chk("reset_nivel", Nivel, 5'b0);
        chk("reset_ocupado", {4'b0, Ocupado}, 5'b0);
        RST = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        // arriba press: level after 6 cycles, pulse exactly at +7
        Barriba = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("arriba_p", pv, (k == 7) ? 5'b00001 : 5'b0);
            chk("arriba_nivel", Nivel, (k >= 6) ? 5'b00001 : 5'b0);
        end
        Barriba = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("arriba_release_p", pv, 5'b0);
            chk("arriba_release_nivel", Nivel, (k >= 6) ? 5'b0 : 5'b00001);
        end

        // 3-cycle centro glitch is rejected
        Bcentro = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        Bcentro = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("glitch_p", pv, 5'b0);
            chk("glitch_nivel", Nivel, 5'b0);
        end

        // derecha and centro together: centro first, derecha next cycle
        Bderecha = 1'b1;
        Bcentro  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("pair_p", pv, (k == 7) ? 5'b10000 : (k == 8) ? 5'b00100 : 5'b0);
            chk("pair_ocupado", {4'b0, Ocupado}, {4'b0, k == 7});
            chk("pair_nivel", Nivel, (k >= 6) ? 5'b10100 : 5'b0);
        end
        Bderecha = 1'b0;
        Bcentro  = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("pair_release_p", pv, 5'b0);
        end

        // all five together: full priority order over five cycles
        {Bcentro, Bizquierda, Bderecha, Babajo, Barriba} = 5'b11111;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("all_p", pv, (k == 7) ? 5'b10000 : (k == 8) ? 5'b00001 : (k == 9) ? 5'b00010 :
                             (k == 10) ? 5'b00100 : (k == 11) ? 5'b01000 : 5'b0);
            chk("all_ocupado", {4'b0, Ocupado}, {4'b0, k >= 7 && k <= 10});
        end
        {Bcentro, Bizquierda, Bderecha, Babajo, Barriba} = 5'b00000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("all_release_p", pv, 5'b0);
        end

        // abajo held 50 cycles: +7 only, or +7/+27/+35/+43 (+51) with auto-repeat
        Babajo = 1'b1;
        for (int t = 1; t <= 64; t++) begin
            tick();
            chk("abajo_hold_p", pv,
                (t == 7 || (AR && t >= 27 && t <= 51 && (t - 27) % 8 == 0)) ? 5'b00010 : 5'b0);
            if (t == 50) Babajo = 1'b0;
        end

        // reset mid-debounce with izquierda held
        Bizquierda = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        RST = 1'b1;
        #1;
        chk("midrst_p", pv, 5'b0);
        chk("midrst_nivel", Nivel, 5'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("midrst_hold_p", pv, 5'b0);
        end
        RST = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("midrst_after_p", pv, (k == 7) ? 5'b01000 : 5'b0);
            chk("midrst_after_nivel", Nivel, (k >= 6) ? 5'b01000 : 5'b0);
        end
        Bizquierda = 1'b0;
        for (int k = 1; k <= 10; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
